// File: rtl/dmac_ctrl_arb.sv
// -----------------------------------------------------------------------------
// dmac_ctrl_arb
//
// Arbitrates the control ports of a cluster DMA (cores, cluster ctrl, FC) onto
// one downstream command channel. It routes each response back to the port
// whose index travels in the command ID. It also registers per-port transfer
// termination events and keeps a sticky interrupt level for each port.
//
// Optional feature: define DMAC_CTRL_ARB_FC_PRIO_EN to give port NB_PORTS-1
// (the FC) absolute priority over the round-robin.
//
// Ports
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   port_req_i / port_gnt_o        per-port request / zero-latency grant
//   port_add_i, port_wen_i,
//   port_be_i, port_wdata_i        per-port command fields
//   port_r_valid_o, port_r_rdata_o,
//   port_r_opc_o                   per-port registered response
//   cmd_*_o, cmd_gnt_i             downstream command and its handshake
//   rsp_*_i                        downstream response (ID = port index)
//   term_evt_i / term_evt_o        termination pulse in / registered copy out
//   irq_clr_i / term_irq_o         per-port irq clear / sticky irq level
//   busy_o                         commands outstanding or any port requesting
//   rsp_err_o                      sticky flag for unroutable or unexpected rsp
// -----------------------------------------------------------------------------
module dmac_ctrl_arb #(
  parameter  int NB_PORTS      = 10,
  parameter  int DATA_WIDTH    = 32,
  parameter  int ADDR_WIDTH    = 32,
  parameter  int OUTSTND_DEPTH = 4,
  localparam int ID_WIDTH      = ($clog2(NB_PORTS) > 1) ? $clog2(NB_PORTS) : 1,
  localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NB_PORTS-1:0]                  port_req_i,
  input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]  port_add_i,
  input  logic [NB_PORTS-1:0]                  port_wen_i,
  input  logic [NB_PORTS-1:0][BE_WIDTH-1:0]    port_be_i,
  input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]  port_wdata_i,
  output logic [NB_PORTS-1:0]                  port_gnt_o,
  output logic [NB_PORTS-1:0]                  port_r_valid_o,
  output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]  port_r_rdata_o,
  output logic [NB_PORTS-1:0]                  port_r_opc_o,
  output logic                                 cmd_req_o,
  output logic [ADDR_WIDTH-1:0]                cmd_add_o,
  output logic                                 cmd_wen_o,
  output logic [BE_WIDTH-1:0]                  cmd_be_o,
  output logic [DATA_WIDTH-1:0]                cmd_wdata_o,
  output logic [ID_WIDTH-1:0]                  cmd_id_o,
  input  logic                                 cmd_gnt_i,
  input  logic                                 rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]                rsp_data_i,
  input  logic                                 rsp_opc_i,
  input  logic [ID_WIDTH-1:0]                  rsp_id_i,
  input  logic [NB_PORTS-1:0]                  term_evt_i,
  input  logic [NB_PORTS-1:0]                  irq_clr_i,
  output logic [NB_PORTS-1:0]                  term_evt_o,
  output logic [NB_PORTS-1:0]                  term_irq_o,
  output logic                                 busy_o,
  output logic                                 rsp_err_o
);

  localparam int                     CNT_WIDTH = $clog2(OUTSTND_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = CNT_WIDTH'(OUTSTND_DEPTH);
  localparam logic [ID_WIDTH-1:0]    LAST_PORT = ID_WIDTH'(NB_PORTS - 1);

  logic [ID_WIDTH-1:0]                 rr_ptr_q,   rr_ptr_d;
  logic [CNT_WIDTH-1:0]                out_cnt_q,  out_cnt_d;
  logic [NB_PORTS-1:0]                 r_valid_q,  r_valid_d;
  logic [NB_PORTS-1:0][DATA_WIDTH-1:0] r_rdata_q,  r_rdata_d;
  logic [NB_PORTS-1:0]                 r_opc_q,    r_opc_d;
  logic [NB_PORTS-1:0]                 term_evt_q, term_evt_d;
  logic [NB_PORTS-1:0]                 term_irq_q, term_irq_d;
  logic                                rsp_err_q,  rsp_err_d;

  logic                any_req;
  logic                win_found;
  logic                fc_win;
  logic [ID_WIDTH-1:0] win_idx;
  logic                accept;
  logic                rsp_dec;
  logic                rsp_id_ok;
  int                  idx;

  // Round-robin search starting at rr_ptr, wrapping past the last port.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    any_req   = |port_req_i;
    win_found = 1'b0;
    win_idx   = '0;
    fc_win    = 1'b0;
    idx       = 0;
    for (int i = 0; i < NB_PORTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NB_PORTS) idx = idx - NB_PORTS;
      if (!win_found && port_req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_WIDTH'(idx);
      end
    end
`ifdef DMAC_CTRL_ARB_FC_PRIO_EN
    // FC overrides the round-robin winner and is flagged so rr_ptr stays put.
    if (port_req_i[NB_PORTS-1]) begin
      win_idx = LAST_PORT;
      fc_win  = 1'b1;
    end
`endif
  end

  // Downstream command, grants and status.
  always_comb begin
    cmd_req_o   = any_req && (out_cnt_q < CNT_MAX);
    cmd_add_o   = '0;
    cmd_wen_o   = 1'b0;
    cmd_be_o    = '0;
    cmd_wdata_o = '0;
    cmd_id_o    = win_idx;
    if (any_req) begin
      cmd_add_o   = port_add_i[win_idx];
      cmd_wen_o   = port_wen_i[win_idx];
      cmd_be_o    = port_be_i[win_idx];
      cmd_wdata_o = port_wdata_i[win_idx];
    end
    accept     = cmd_req_o && cmd_gnt_i;
    port_gnt_o = '0;
    if (accept) port_gnt_o[win_idx] = 1'b1;
    busy_o = (out_cnt_q != '0) || any_req;
  end

  // Next-state logic for the arbiter pointer, counter and response path.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    out_cnt_d  = out_cnt_q;
    r_valid_d  = '0;
    r_rdata_d  = r_rdata_q;
    r_opc_d    = r_opc_q;
    term_evt_d = term_evt_i;
    // Set dominates clear when both arrive in the same cycle.
    term_irq_d = (term_irq_q & ~irq_clr_i) | term_evt_i;

    // A response with nothing outstanding is unexpected and is dropped.
    rsp_dec   = rsp_valid_i && (out_cnt_q != '0);
    rsp_id_ok = int'(rsp_id_i) < NB_PORTS;
    rsp_err_d = rsp_err_q | (rsp_valid_i && (!rsp_dec || !rsp_id_ok));

    if (accept && !fc_win)
      rr_ptr_d = (win_idx == LAST_PORT) ? '0 : win_idx + 1'b1;

    case ({accept, rsp_dec})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase

    if (rsp_dec && rsp_id_ok) begin
      r_valid_d[rsp_id_i] = 1'b1;
      r_rdata_d[rsp_id_i] = rsp_data_i;
      r_opc_d[rsp_id_i]   = rsp_opc_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      out_cnt_q  <= '0;
      r_valid_q  <= '0;
      // NOTE: the per-port read data array is reset too, so the ports see
      // zeros rather than stale data after reset; this costs reset fan-out.
      r_rdata_q  <= '0;
      r_opc_q    <= '0;
      term_evt_q <= '0;
      term_irq_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      out_cnt_q  <= out_cnt_d;
      r_valid_q  <= r_valid_d;
      r_rdata_q  <= r_rdata_d;
      r_opc_q    <= r_opc_d;
      term_evt_q <= term_evt_d;
      term_irq_q <= term_irq_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign port_r_valid_o = r_valid_q;
  assign port_r_rdata_o = r_rdata_q;
  assign port_r_opc_o   = r_opc_q;
  assign term_evt_o     = term_evt_q;
  assign term_irq_o     = term_irq_q;
  assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_dmac_ctrl_arb.sv
// -----------------------------------------------------------------------------
// tb_dmac_ctrl_arb
//
// Self-checking bench for dmac_ctrl_arb with default parameters (10 ports,
// depth 4). Directed scenarios come first, then randomized traffic, all checked
// against a reference model kept in this file. The model chooses the winner
// by smallest circular distance from the pointer. It tracks the outstanding
// count, last data per port, irq bits and the error flag as plain variables.
// -----------------------------------------------------------------------------
module tb_dmac_ctrl_arb;

  localparam int NB    = 10;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BEW   = DW / 8;
  localparam int IDW   = 4;
  localparam int DEPTH = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b0;
  logic [NB-1:0]         port_req;
  logic [NB-1:0][AW-1:0] port_add;
  logic [NB-1:0]         port_wen;
  logic [NB-1:0][BEW-1:0] port_be;
  logic [NB-1:0][DW-1:0] port_wdata;
  logic [NB-1:0]         port_gnt_o;
  logic [NB-1:0]         port_r_valid_o;
  logic [NB-1:0][DW-1:0] port_r_rdata_o;
  logic [NB-1:0]         port_r_opc_o;
  logic                  cmd_req_o;
  logic [AW-1:0]         cmd_add_o;
  logic                  cmd_wen_o;
  logic [BEW-1:0]        cmd_be_o;
  logic [DW-1:0]         cmd_wdata_o;
  logic [IDW-1:0]        cmd_id_o;
  logic                  cmd_gnt;
  logic                  rsp_valid;
  logic [DW-1:0]         rsp_data;
  logic                  rsp_opc;
  logic [IDW-1:0]        rsp_id;
  logic [NB-1:0]         term_evt;
  logic [NB-1:0]         irq_clr;
  logic [NB-1:0]         term_evt_o;
  logic [NB-1:0]         term_irq_o;
  logic                  busy_o;
  logic                  rsp_err_o;

  always #5 clk_i = ~clk_i;

  dmac_ctrl_arb #(
    .NB_PORTS     (NB),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .OUTSTND_DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .port_req_i    (port_req),
    .port_add_i    (port_add),
    .port_wen_i    (port_wen),
    .port_be_i     (port_be),
    .port_wdata_i  (port_wdata),
    .port_gnt_o    (port_gnt_o),
    .port_r_valid_o(port_r_valid_o),
    .port_r_rdata_o(port_r_rdata_o),
    .port_r_opc_o  (port_r_opc_o),
    .cmd_req_o     (cmd_req_o),
    .cmd_add_o     (cmd_add_o),
    .cmd_wen_o     (cmd_wen_o),
    .cmd_be_o      (cmd_be_o),
    .cmd_wdata_o   (cmd_wdata_o),
    .cmd_id_o      (cmd_id_o),
    .cmd_gnt_i     (cmd_gnt),
    .rsp_valid_i   (rsp_valid),
    .rsp_data_i    (rsp_data),
    .rsp_opc_i     (rsp_opc),
    .rsp_id_i      (rsp_id),
    .term_evt_i    (term_evt),
    .irq_clr_i     (irq_clr),
    .term_evt_o    (term_evt_o),
    .term_irq_o    (term_irq_o),
    .busy_o        (busy_o),
    .rsp_err_o     (rsp_err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int            m_rr;
  int            m_cnt;
  bit            m_err;
  logic [NB-1:0] m_irq;
  logic [NB-1:0] m_evt;
  logic [NB-1:0] m_rvalid;
  logic [NB-1:0] m_opc;
  logic [DW-1:0] m_rdata [NB];

  // Values observed during the last cycle() call, for directed checks.
  logic [NB-1:0]  obs_gnt;
  logic [IDW-1:0] obs_id;
  logic           obs_req;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Winner = requesting port with the smallest circular distance from m_rr.
  function automatic int model_winner();
    int best      = -1;
    int best_dist = NB;
`ifdef DMAC_CTRL_ARB_FC_PRIO_EN
    if (port_req[NB-1]) return NB - 1;
`endif
    for (int p = 0; p < NB; p++) begin
      if (port_req[p]) begin
        int d;
        d = (p - m_rr + NB) % NB;
        if (d < best_dist) begin
          best_dist = d;
          best      = p;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_rr     = 0;
    m_cnt    = 0;
    m_err    = 1'b0;
    m_irq    = '0;
    m_evt    = '0;
    m_rvalid = '0;
    m_opc    = '0;
    for (int p = 0; p < NB; p++) m_rdata[p] = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".r_valid"},  port_r_valid_o, m_rvalid);
    check({tag, ".r_opc"},    port_r_opc_o,   m_opc);
    check({tag, ".term_evt"}, term_evt_o,     m_evt);
    check({tag, ".term_irq"}, term_irq_o,     m_irq);
    check({tag, ".rsp_err"},  rsp_err_o,      m_err);
    for (int p = 0; p < NB; p++)
      check($sformatf("%s.rdata[%0d]", tag, p), port_r_rdata_o[p], m_rdata[p]);
  endtask

  task automatic rand_fields();
    for (int p = 0; p < NB; p++) begin
      port_add[p]   = $urandom;
      port_wdata[p] = $urandom;
      port_be[p]    = BEW'($urandom);
      port_wen[p]   = 1'($urandom);
    end
  endtask

  // One clock: inputs are already driven; check combinational outputs, clock,
  // advance the model, then check registered outputs.
  task automatic cycle();
    int w;
    bit req;
    bit acc;
    bit dec;
    #2;
    w   = model_winner();
    req = (w >= 0) && (m_cnt < DEPTH);
    acc = req && cmd_gnt;
    check("cmd_req",  cmd_req_o,  req);
    check("cmd_id",   cmd_id_o,   (w >= 0) ? w : 0);
    check("port_gnt", port_gnt_o, acc ? (64'd1 << w) : 64'd0);
    check("cmd_add",  cmd_add_o,  (w >= 0) ? port_add[w]   : '0);
    check("cmd_wdat", cmd_wdata_o,(w >= 0) ? port_wdata[w] : '0);
    check("cmd_wen",  cmd_wen_o,  (w >= 0) ? port_wen[w]   : 1'b0);
    check("cmd_be",   cmd_be_o,   (w >= 0) ? port_be[w]    : '0);
    check("busy",     busy_o,     (m_cnt > 0) || (port_req != '0));
    obs_gnt = port_gnt_o;
    obs_id  = cmd_id_o;
    obs_req = cmd_req_o;
    @(posedge clk_i);
    dec      = rsp_valid && (m_cnt > 0);
    m_rvalid = '0;
    if (rsp_valid && (!dec || rsp_id >= NB)) m_err = 1'b1;
    if (dec && rsp_id < NB) begin
      m_rvalid[rsp_id] = 1'b1;
      m_rdata[rsp_id]  = rsp_data;
      m_opc[rsp_id]    = rsp_opc;
    end
    if (acc) begin
`ifdef DMAC_CTRL_ARB_FC_PRIO_EN
      if (w != NB - 1) m_rr = (w + 1) % NB;
`else
      m_rr = (w + 1) % NB;
`endif
    end
    m_cnt = m_cnt + (acc ? 1 : 0) - (dec ? 1 : 0);
    m_irq = (m_irq & ~irq_clr) | term_evt;
    m_evt = term_evt;
    #1;
    check_regs("cyc");
  endtask

  task automatic idle_inputs();
    port_req  = '0;
    cmd_gnt   = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
    rsp_opc   = 1'b0;
    term_evt  = '0;
    irq_clr   = '0;
  endtask

  // Asserts reset, checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    #1;
    model_reset();
    check_regs("reset");
    check("reset.cmd_req", cmd_req_o, 1'b0);
    check("reset.busy",    busy_o,    1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    int seq_a [6];
    int seq_b [4];
    int last;
    int ngrants;

    seq_a = '{0, 3, 5, 0, 3, 5};
`ifdef DMAC_CTRL_ARB_FC_PRIO_EN
    seq_b = '{9, 9, 9, 9};
`else
    seq_b = '{0, 9, 0, 9};
`endif
    idle_inputs();
    rand_fields();
    #1;
    do_reset();

    // Round-robin over ports 0, 3, 5 with a response every busy cycle.
    port_req = NB'(10'b00_0010_1001);
    cmd_gnt  = 1'b1;
    last     = 0;
    for (int i = 0; i < 6; i++) begin
      rsp_valid = (m_cnt > 0);
      rsp_id    = IDW'(last);
      rsp_data  = $urandom;
      cycle();
      check($sformatf("rr_seq_id[%0d]", i),  obs_id,  seq_a[i]);
      check($sformatf("rr_seq_gnt[%0d]", i), obs_gnt, 64'd1 << seq_a[i]);
      last = seq_a[i];
    end

    // Fill the outstanding window from port 1 with no responses.
    do_reset();
    port_req = NB'(10'b00_0000_0010);
    cmd_gnt  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("fill_gnt[%0d]", i), obs_gnt, 64'h2);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      check($sformatf("full_req[%0d]", i), obs_req, 1'b0);
    end
    rsp_valid = 1'b1;
    rsp_id    = IDW'(1);
    cycle();
    check("full_rsp_same_cycle", obs_gnt, 64'h0);
    rsp_valid = 1'b0;
    cycle();
    check("full_regrant", obs_gnt, 64'h2);
    cycle();
    check("full_again", obs_req, 1'b0);

    // Response routing to port 2, then hold of the read data.
    port_req  = '0;
    rsp_valid = 1'b1;
    rsp_id    = IDW'(2);
    rsp_data  = 32'hDEAD_BEEF;
    rsp_opc   = 1'b1;
    cycle();
    check("route_valid", port_r_valid_o,    64'h4);
    check("route_data",  port_r_rdata_o[2], 64'hDEAD_BEEF);
    rsp_valid = 1'b0;
    rsp_opc   = 1'b0;
    cycle();
    check("route_valid_low", port_r_valid_o,    64'h0);
    check("route_data_hold", port_r_rdata_o[2], 64'hDEAD_BEEF);

    // Bad ID 12 with 3 outstanding: no routing, error, count goes to 2.
    rsp_valid = 1'b1;
    rsp_id    = IDW'(12);
    cycle();
    check("badid_valid", port_r_valid_o, 64'h0);
    check("badid_err",   rsp_err_o,      1'b1);
    rsp_valid = 1'b0;
    port_req  = NB'(10'b00_0000_0010);
    ngrants   = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (obs_gnt != '0) ngrants++;
    end
    check("badid_room", ngrants, 2);
    check("badid_err_sticky", rsp_err_o, 1'b1);

    // Reset mid-operation, then a response with nothing outstanding.
    do_reset();
    rsp_valid = 1'b1;
    rsp_id    = IDW'(0);
    cycle();
    check("post_reset_drop_err",   rsp_err_o,      1'b1);
    check("post_reset_drop_valid", port_r_valid_o, 64'h0);
    do_reset();

    // Termination events and sticky irq with set/clear collision.
    term_evt = NB'(10'b00_0001_0000);
    irq_clr  = NB'(10'b00_0001_0000);
    cycle();
    check("irq_set_wins", term_irq_o[4], 1'b1);
    check("evt_delayed",  term_evt_o[4], 1'b1);
    term_evt = '0;
    cycle();
    check("irq_cleared", term_irq_o[4], 1'b0);
    check("evt_pulse",   term_evt_o[4], 1'b0);
    irq_clr = '0;

    // Ports 0 and 9 competing.
    do_reset();
    port_req = NB'(10'b10_0000_0001);
    cmd_gnt  = 1'b1;
    last     = 0;
    for (int i = 0; i < 4; i++) begin
      rsp_valid = (m_cnt > 0);
      rsp_id    = IDW'(last);
      cycle();
      check($sformatf("fc_seq[%0d]", i), obs_gnt, 64'd1 << seq_b[i]);
      last = seq_b[i];
    end

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      port_req  = NB'($urandom & $urandom);
      cmd_gnt   = ($urandom_range(0, 3) != 0);
      rsp_valid = ($urandom_range(0, 2) == 0);
      rsp_id    = ($urandom_range(0, 7) == 0) ? IDW'($urandom_range(10, 15))
                                              : IDW'($urandom_range(0, 9));
      rsp_data  = $urandom;
      rsp_opc   = 1'($urandom);
      term_evt  = NB'($urandom & $urandom & $urandom);
      irq_clr   = NB'($urandom & $urandom);
      cycle();
    end

    idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmac_ctrl_arb.md
DMAC_CTRL_ARB -- requirements
Module: dmac_ctrl_arb

Interface
REQ-001 Parameter NB_PORTS, default 10, number of control ports (cores + cluster ctrl + FC), 2..32.
REQ-002 Parameter DATA_WIDTH, default 32, control data width.
REQ-003 Parameter ADDR_WIDTH, default 32, control address width.
REQ-004 Parameter OUTSTND_DEPTH, default 4, maximum accepted commands awaiting response, 1..16.
REQ-005 Derived ID_WIDTH = max(1, clog2(NB_PORTS)); BE_WIDTH = DATA_WIDTH/8.
REQ-006 clk_i  in  1  single clock; all logic on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 port_req_i  in  NB_PORTS  per-port request.
REQ-009 port_add_i / port_wen_i / port_be_i / port_wdata_i  in  NB_PORTS x ADDR_WIDTH / 1 / BE_WIDTH / DATA_WIDTH  per-port command fields.
REQ-010 port_gnt_o  out  NB_PORTS  per-port grant, one-hot or zero.
REQ-011 port_r_valid_o / port_r_rdata_o / port_r_opc_o  out  NB_PORTS / NB_PORTS x DATA_WIDTH / NB_PORTS  per-port response.
REQ-012 cmd_req_o, cmd_add_o, cmd_wen_o, cmd_be_o, cmd_wdata_o, cmd_id_o (ID_WIDTH)  out  downstream DMA command; cmd_gnt_i  in  1.
REQ-013 rsp_valid_i  in  1, rsp_data_i  in  DATA_WIDTH, rsp_opc_i  in  1, rsp_id_i  in  ID_WIDTH  downstream response.
REQ-014 term_evt_i  in  NB_PORTS  per-port transfer-termination pulse; irq_clr_i  in  NB_PORTS  per-port irq clear.
REQ-015 term_evt_o  out  NB_PORTS  registered event pulse; term_irq_o  out  NB_PORTS  sticky irq level.
REQ-016 busy_o  out  1  high while any command outstanding or any port_req_i high; rsp_err_o  out  1  sticky bad-ID flag.

Function
REQ-017 Arbitration combinational: winner = first requesting port at or after rr_ptr, wrapping at NB_PORTS-1 -> 0.
REQ-018 cmd_req_o = (any port_req_i) AND (out_cnt < OUTSTND_DEPTH); command fields and cmd_id_o = winner index, zero when no request.
REQ-019 port_gnt_o[winner] = cmd_req_o AND cmd_gnt_i; zero-latency grant; all other grants 0.
REQ-020 On accepted command (cmd_req_o AND cmd_gnt_i) rr_ptr <= winner+1 modulo NB_PORTS; otherwise rr_ptr holds.
REQ-021 out_cnt increments on accepted command, decrements on rsp_valid_i; both same cycle -> unchanged; never exceeds OUTSTND_DEPTH or underflows.
REQ-022 out_cnt == OUTSTND_DEPTH -> cmd_req_o 0, all grants 0 until a response arrives; response in the full cycle does not allow a same-cycle grant.
REQ-023 Response routing: one-cycle registered latency; rsp_valid_i with rsp_id_i = k < NB_PORTS -> port_r_valid_o[k] = 1 next cycle with rsp_data_i/rsp_opc_i captured.
REQ-024 rsp_valid_i with rsp_id_i >= NB_PORTS -> no port response, out_cnt still decrements, rsp_err_o set until reset.
REQ-025 rsp_valid_i with out_cnt == 0 -> dropped, rsp_err_o set, out_cnt stays 0.
REQ-026 port_r_rdata_o holds last value for its port when r_valid low.
REQ-027 term_evt_o[k] = term_evt_i[k] delayed one cycle.
REQ-028 term_irq_o[k] set on term_evt_i[k], cleared on irq_clr_i[k]; simultaneous set and clear -> set wins.

Reset
REQ-029 rst_i high -> immediately: rr_ptr 0, out_cnt 0, all port_r_valid_o/port_r_rdata_o/port_r_opc_o 0, term_evt_o 0, term_irq_o 0, rsp_err_o 0.
REQ-030 Reset mid-operation discards outstanding count; responses arriving after reset release fall under REQ-025.
REQ-031 Combinational outputs (cmd_*, port_gnt_o, busy_o) follow REQ-016..019 with reset register values.

Configuration
REQ-032 Macro DMAC_CTRL_ARB_FC_PRIO_EN defined -> port NB_PORTS-1 has absolute priority over round-robin whenever requesting; accepting it does not move rr_ptr.
REQ-033 Macro undefined -> pure round-robin per REQ-017/020 for all ports.

Verification
REQ-034 Ports 0,3,5 request continuously, cmd_gnt_i=1, rsp returned each cycle -> grants 0,3,5,0,3,5; cmd_id_o matches.
REQ-035 OUTSTND_DEPTH=4, no responses, port 1 requesting -> exactly 4 grants, cmd_req_o 0 after; one rsp_valid_i -> one further grant next cycle.
REQ-036 rsp_valid_i, rsp_id_i=2, rsp_data_i=0xDEADBEEF -> next cycle port_r_valid_o[2]=1, port_r_rdata_o[2]=0xDEADBEEF, others 0.
REQ-037 rsp_id_i=12 with NB_PORTS=10 -> no port r_valid, out_cnt decrements, rsp_err_o=1 until rst_i.
REQ-038 term_evt_i[4] and irq_clr_i[4] same cycle -> term_irq_o[4]=1, term_evt_o[4]=1 one cycle later; clear alone next -> term_irq_o[4]=0.
REQ-039 With DMAC_CTRL_ARB_FC_PRIO_EN, ports 0 and 9 requesting -> port 9 granted every cycle; without macro -> alternating 0,9.
